if_fetch_buffer: RTL and testbench
==================================

Name: if_fetch_buffer

Overview:
- Instruction-fetch front end that sits directly upstream of the core's instruction bus.
- Accepts the core's next-PC (if_nxt_pc) and issues single-outstanding word fetches on a simple request/ack instruction-memory bus.
- Queues the returned parcels with their PCs in a DEPTH-entry FIFO and presents them on the core's if_parcel_* inputs.
- Honours the core's if_stall and if_flush, and reports misaligned and faulted fetches.

Parameters:
- XLEN, 32, address/data width.
- PARCEL_SIZE, 32, parcel width in bits; must equal XLEN.
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PC_INIT, 'h200, fetch PC after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- if_nxt_pc  in  XLEN  next fetch address from the core.
- if_stall_nxt_pc  out  1  high = buffer cannot accept if_nxt_pc this cycle.
- if_stall  in  1  high = core does not consume the FIFO head.
- if_flush  in  1  discard all queued and in-flight fetches.
- if_parcel  out  PARCEL_SIZE  head parcel.
- if_parcel_pc  out  XLEN  PC of the head parcel.
- if_parcel_valid  out  PARCEL_SIZE/16  all ones when the head is valid, else 0.
- if_parcel_misaligned  out  1  head entry is a misaligned-fetch marker.
- if_parcel_page_fault  out  1  head entry is a bus-faulted fetch.
- imem_req  out  1  memory request.
- imem_adr  out  XLEN  request address; held stable while imem_req is high.
- imem_q  in  XLEN  read data; valid with imem_ack.
- imem_ack  in  1  request completed successfully.
- imem_err  in  1  request completed with an error.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO empty; state IDLE; imem_req=0, imem_adr=PC_INIT.
  - if_parcel_valid=0, if_parcel=0, if_parcel_pc=PC_INIT, if_parcel_misaligned=0, if_parcel_page_fault=0.
  - if_stall_nxt_pc=1 during reset.
  - Reset mid-request: the request is abandoned; any late ack/err after reset is ignored.
- Credit rule:
  - if_stall_nxt_pc = rst | (state!=IDLE) | (count == DEPTH).
  - count is the FIFO occupancy. With a single outstanding request, a push into a full FIFO is impossible.
- States: IDLE, WAIT, DISCARD.
- IDLE:
  - If !if_stall_nxt_pc and !if_flush, the buffer accepts if_nxt_pc.
  - Aligned address (if_nxt_pc[1:0]==0): imem_adr <= if_nxt_pc, imem_req <= 1, go to WAIT.
  - Misaligned address: no bus request. Next cycle, push an entry with pc=if_nxt_pc, parcel=0, misaligned=1. Stay in IDLE.
- WAIT:
  - imem_req stays high with imem_adr stable until imem_ack or imem_err.
  - On ack: push {imem_q, imem_adr, mis=0, pf=0}, drop imem_req, go to IDLE.
  - On err: push {0, imem_adr, mis=0, pf=1}, drop imem_req, go to IDLE.
  - ack and err together: err wins.
  - if_flush while in WAIT: go to DISCARD; imem_req stays high until the response arrives.
- DISCARD:
  - The ack/err response is dropped (no push), imem_req drops, go to IDLE.
  - A flush in DISCARD has no further effect.
- Output and pop:
  - The head is registered from the FIFO.
  - Pop when count!=0 and !if_stall and !if_flush.
  - Latency: the ack cycle pushes; the parcel is visible on if_parcel one cycle after ack (FIFO was empty).
- Simultaneous push and pop: allowed; count is unchanged.
- Flush:
  - In the flush cycle, count <= 0, outputs invalid next cycle, and no if_nxt_pc is accepted.
  - A push in the flush cycle is dropped.
- Pointer arithmetic: log2(DEPTH)-bit pointers wrap naturally; count is log2(DEPTH)+1 bits.

Optional Feature:
- Macro: IF_FETCH_BUFFER_BYPASS_EN.
- Defined:
  - When the FIFO is empty, the state is WAIT, imem_ack=1 and !if_flush, imem_q and imem_adr are driven combinationally onto if_parcel/if_parcel_pc with if_parcel_valid all ones in the ack cycle.
  - If !if_stall in that cycle, the entry is consumed and not pushed. If if_stall=1, it is pushed as normal.
  - Errors never bypass.
- Undefined: all outputs come from the FIFO head register; minimum ack-to-valid latency is 1 cycle.

Test Plan:
- Reset release, if_nxt_pc='h200, memory acks 2 cycles after each request with imem_q='h00000013 -> imem_adr='h200, parcel 'h00000013 / pc 'h200 valid 1 cycle after ack (0 cycles with BYPASS_EN), if_parcel_valid=2'b11.
- if_stall held high, fetch 'h200,'h204,'h208,'h20C -> count=4, if_stall_nxt_pc=1, no 5th request. Release stall -> parcels pop in order, one per cycle.
- if_flush in the 2nd WAIT cycle of the fetch of 'h300, then ack with 'hDEADBEEF -> no parcel delivered; next fetch 'h100 returns its own data first.
- if_nxt_pc='h202 -> no imem_req; entry with pc 'h202, if_parcel_misaligned=1.
- imem_err (and, separately, ack+err together) on the fetch of 'h400 -> entry with if_parcel_page_fault=1, pc 'h400, parcel 0.
- rst asserted during WAIT, late ack next cycle -> ack ignored, FIFO empty, imem_req=0, imem_adr='h200.

Source files
------------

// File: rtl/if_fetch_buffer.sv
// Instruction-fetch buffer: single-outstanding imem fetches, queued with their PCs in a DEPTH-entry FIFO.
// Optional macro IF_FETCH_BUFFER_BYPASS_EN forwards an ack straight to the core when the FIFO is empty.
module if_fetch_buffer #(
   parameter int              XLEN        = 32,
   parameter int              PARCEL_SIZE = 32,
   parameter int              DEPTH       = 4,
   parameter logic [XLEN-1:0] PC_INIT     = 'h200
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [XLEN-1:0]           if_nxt_pc,
   output logic                      if_stall_nxt_pc,
   input  logic                      if_stall,
   input  logic                      if_flush,
   output logic [PARCEL_SIZE-1:0]    if_parcel,
   output logic [XLEN-1:0]           if_parcel_pc,
   output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
   output logic                      if_parcel_misaligned,
   output logic                      if_parcel_page_fault,
   output logic                      imem_req,
   output logic [XLEN-1:0]           imem_adr,
   input  logic [XLEN-1:0]           imem_q,
   input  logic                      imem_ack,
   input  logic                      imem_err
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int VLD_W = PARCEL_SIZE / 16;

   typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_e;

   typedef struct packed {
      logic [PARCEL_SIZE-1:0] parcel;
      logic [XLEN-1:0]        pc;
      logic                   misaligned;
      logic                   page_fault;
   } entry_t;

   state_e           state_q, state_d;
   logic             req_q, req_d;
   logic [XLEN-1:0]  adr_q, adr_d;
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   entry_t           mem_q [DEPTH];

   logic   push, pop, accept, resp, head_valid, byp_valid, out_valid;
   entry_t push_entry, head;

   assign head_valid      = (count_q != '0);
   assign head            = mem_q[rd_ptr_q];
   assign if_stall_nxt_pc = rst | (state_q != IDLE) | (count_q == CNT_W'(DEPTH));
   assign accept          = ~if_stall_nxt_pc & ~if_flush;
   assign resp            = imem_ack | imem_err;
   assign pop             = head_valid & ~if_stall & ~if_flush;
   assign imem_req        = req_q;
   assign imem_adr        = adr_q;

`ifdef IF_FETCH_BUFFER_BYPASS_EN
   assign byp_valid = ~rst & (state_q == WAIT) & imem_ack & ~imem_err & ~if_flush & ~head_valid;
`else
   assign byp_valid = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      adr_d      = adr_q;
      push       = 1'b0;
      push_entry = '0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (if_nxt_pc[1:0] == 2'b00) begin
                  adr_d   = if_nxt_pc;
                  req_d   = 1'b1;
                  state_d = WAIT;
               end else begin
                  push                  = 1'b1;
                  push_entry.pc         = if_nxt_pc;
                  push_entry.misaligned = 1'b1;
               end
            end
         end
         WAIT: begin
            if (resp) begin
               // A response in the flush cycle itself is simply dropped; no DISCARD needed.
               req_d         = 1'b0;
               state_d       = IDLE;
               push          = ~if_flush & ~(byp_valid & ~if_stall);
               push_entry.pc = adr_q;
               if (imem_err) push_entry.page_fault = 1'b1;
               else          push_entry.parcel     = imem_q;
            end else if (if_flush) begin
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (resp) begin
               req_d   = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         adr_q    <= PC_INIT;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         state_q <= state_d;
         req_q   <= req_d;
         adr_q   <= adr_d;
         if (if_flush) begin
            wr_ptr_q <= rd_ptr_q;
            count_q  <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push & ~pop)      count_q <= count_q + 1'b1;
            else if (pop & ~push) count_q <= count_q - 1'b1;
         end
      end
   end

   // NOTE: the storage array has no reset; count_q alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= push_entry;
   end

   always_comb begin
      out_valid            = 1'b0;
      if_parcel            = '0;
      if_parcel_pc         = PC_INIT;
      if_parcel_misaligned = 1'b0;
      if_parcel_page_fault = 1'b0;
      if (byp_valid) begin
         out_valid    = 1'b1;
         if_parcel    = imem_q;
         if_parcel_pc = adr_q;
      end else if (head_valid) begin
         out_valid            = 1'b1;
         if_parcel            = head.parcel;
         if_parcel_pc         = head.pc;
         if_parcel_misaligned = head.misaligned;
         if_parcel_page_fault = head.page_fault;
      end
      if_parcel_valid = {VLD_W{out_valid}};
   end

endmodule

// File: tb/tb_if_fetch_buffer.sv
// Self-checking bench for if_fetch_buffer: directed scenarios plus random traffic against a queue model.
// Honours IF_FETCH_BUFFER_BYPASS_EN when the design is built with it.
module tb_if_fetch_buffer;
   localparam int          DEPTH   = 4;
   localparam logic [31:0] PC_INIT = 32'h200;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] if_nxt_pc = '0;
   logic        if_stall_nxt_pc;
   logic        if_stall = 1'b0;
   logic        if_flush = 1'b0;
   logic [31:0] if_parcel;
   logic [31:0] if_parcel_pc;
   logic [1:0]  if_parcel_valid;
   logic        if_parcel_misaligned;
   logic        if_parcel_page_fault;
   logic        imem_req;
   logic [31:0] imem_adr;
   logic [31:0] imem_q = '0;
   logic        imem_ack = 1'b0;
   logic        imem_err = 1'b0;

   if_fetch_buffer #(.XLEN(32), .PARCEL_SIZE(32), .DEPTH(DEPTH), .PC_INIT(PC_INIT)) dut (
      .clk(clk), .rst(rst), .if_nxt_pc(if_nxt_pc), .if_stall_nxt_pc(if_stall_nxt_pc),
      .if_stall(if_stall), .if_flush(if_flush), .if_parcel(if_parcel), .if_parcel_pc(if_parcel_pc),
      .if_parcel_valid(if_parcel_valid), .if_parcel_misaligned(if_parcel_misaligned),
      .if_parcel_page_fault(if_parcel_page_fault), .imem_req(imem_req), .imem_adr(imem_adr),
      .imem_q(imem_q), .imem_ack(imem_ack), .imem_err(imem_err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

   typedef struct {
      logic [31:0] parcel;
      logic [31:0] pc;
      bit          mis;
      bit          pf;
   } ent_t;

   // Reference model: what the core should see, kept as a plain queue plus the outstanding fetch.
   ent_t        mq[$];
   bit          m_known  = 1'b0;
   bit          m_out    = 1'b0;
   bit          m_cancel = 1'b0;
   logic [31:0] m_adr    = PC_INIT;
   bit          t_snp, t_byp;
   int          n_checks = 0;
   int          n_fail   = 0;

   // Apply inputs for one cycle and compare every output against the model.
   task automatic drive(input logic r, input logic [31:0] pc, input logic st, input logic fl,
                        input logic ak, input logic er, input logic [31:0] dq);
      logic        e_valid;
      logic [31:0] e_parcel, e_pc;
      bit          e_mis, e_pf;
      rst = r; if_nxt_pc = pc; if_stall = st; if_flush = fl;
      imem_ack = ak; imem_err = er; imem_q = dq;
      #1;
      t_snp = r || m_out || (mq.size() == DEPTH);
      t_byp = 1'b0;
`ifdef IF_FETCH_BUFFER_BYPASS_EN
      t_byp = !r && m_out && !m_cancel && (mq.size() == 0) && ak && !er && !fl;
`endif
      if (r || m_known) begin
         n_checks++;
         if (if_stall_nxt_pc !== t_snp) begin
            n_fail++;
            $display("FAIL stall_nxt_pc @%0t: got %b want %b", $time, if_stall_nxt_pc, t_snp);
         end
      end
      if (!m_known) return;
      e_valid = t_byp || (mq.size() != 0);
      e_parcel = '0; e_pc = '0; e_mis = 0; e_pf = 0;
      if (t_byp) begin
         e_parcel = dq; e_pc = m_adr;
      end else if (mq.size() != 0) begin
         e_parcel = mq[0].parcel; e_pc = mq[0].pc; e_mis = mq[0].mis; e_pf = mq[0].pf;
      end
      n_checks++;
      if (imem_req !== m_out) begin
         n_fail++;
         $display("FAIL imem_req @%0t: got %b want %b", $time, imem_req, m_out);
      end
      n_checks++;
      if (imem_adr !== m_adr) begin
         n_fail++;
         $display("FAIL imem_adr @%0t: got %h want %h", $time, imem_adr, m_adr);
      end
      n_checks++;
      if (if_parcel_valid !== {2{e_valid}}) begin
         n_fail++;
         $display("FAIL parcel_valid @%0t: got %b want %b", $time, if_parcel_valid, {2{e_valid}});
      end
      n_checks++;
      if ({if_parcel, if_parcel_misaligned, if_parcel_page_fault} !== {e_parcel, e_mis, e_pf}) begin
         n_fail++;
         $display("FAIL parcel/flags @%0t: got %h/%b/%b want %h/%b/%b", $time, if_parcel,
                  if_parcel_misaligned, if_parcel_page_fault, e_parcel, e_mis, e_pf);
      end
      if (e_valid) begin
         n_checks++;
         if (if_parcel_pc !== e_pc) begin
            n_fail++;
            $display("FAIL parcel_pc @%0t: got %h want %h", $time, if_parcel_pc, e_pc);
         end
      end
   endtask

   // Clock edge: advance the model with the inputs applied by drive().
   task automatic tick();
      ent_t e;
      bit   do_push, pop, accept;
      @(posedge clk);
      if (rst) begin
         mq.delete(); m_out = 0; m_cancel = 0; m_adr = PC_INIT; m_known = 1;
      end else if (m_known) begin
         do_push = 0;
         e = '{parcel: '0, pc: '0, mis: 0, pf: 0};
         pop    = (mq.size() != 0) && !if_stall && !if_flush;
         accept = !t_snp && !if_flush;
         if (m_out && (imem_ack || imem_err)) begin
            if (!m_cancel && !if_flush && !(t_byp && !if_stall)) begin
               do_push = 1;
               e.pc = m_adr;
               e.pf = imem_err;
               e.parcel = imem_err ? 32'h0 : imem_q;
            end
            m_out = 0; m_cancel = 0;
         end else if (m_out && if_flush) begin
            m_cancel = 1;
         end
         if (accept) begin
            if (if_nxt_pc[1:0] == 2'b00) begin
               m_out = 1; m_cancel = 0; m_adr = if_nxt_pc;
            end else begin
               do_push = 1; e.pc = if_nxt_pc; e.mis = 1;
            end
         end
         if (if_flush) mq.delete();
         else begin
            if (pop) void'(mq.pop_front());
            if (do_push) mq.push_back(e);
         end
      end
      @(negedge clk);
   endtask

   task automatic cycle(input logic r, input logic [31:0] pc, input logic st, input logic fl,
                        input logic ak, input logic er, input logic [31:0] dq);
      drive(r, pc, st, fl, ak, er, dq);
      tick();
   endtask

   // Two flush+ack cycles leave the buffer idle and empty from any state.
   task automatic drain();
      cycle(0, 32'h0, 1, 1, 1, 0, 32'h0);
      cycle(0, 32'h0, 1, 1, 1, 0, 32'h0);
   endtask

   task automatic test_reset();
      cycle(1, PC_INIT, 0, 0, 0, 0, 32'h0);
      cycle(1, PC_INIT, 0, 0, 0, 0, 32'h0);
      n_checks++;
      if ({if_stall_nxt_pc, imem_req, imem_adr} !== {1'b1, 1'b0, 32'h200}) begin
         n_fail++;
         $display("FAIL reset_bus: got snp=%b req=%b adr=%h want 1/0/200", if_stall_nxt_pc, imem_req, imem_adr);
      end
      n_checks++;
      if ({if_parcel_valid, if_parcel, if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault}
          !== {2'b00, 32'h0, 32'h200, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_head: got v=%b p=%h pc=%h m=%b f=%b", if_parcel_valid, if_parcel,
                  if_parcel_pc, if_parcel_misaligned, if_parcel_page_fault);
      end
   endtask

   task automatic test_basic_fetch();
      cycle(0, 32'h200, 0, 0, 0, 0, 32'h0);
      n_checks++;
      if ({imem_req, imem_adr} !== {1'b1, 32'h200}) begin
         n_fail++;
         $display("FAIL basic_req: got req=%b adr=%h want 1/200", imem_req, imem_adr);
      end
      cycle(0, 32'h204, 0, 0, 0, 0, 32'h0);
      drive(0, 32'h204, 0, 0, 1, 0, 32'h00000013);
`ifdef IF_FETCH_BUFFER_BYPASS_EN
      n_checks++;
      if ({if_parcel_valid, if_parcel, if_parcel_pc} !== {2'b11, 32'h13, 32'h200}) begin
         n_fail++;
         $display("FAIL basic_bypass: got v=%b p=%h pc=%h", if_parcel_valid, if_parcel, if_parcel_pc);
      end
      tick();
`else
      tick();
      n_checks++;
      if ({if_parcel_valid, if_parcel, if_parcel_pc} !== {2'b11, 32'h13, 32'h200}) begin
         n_fail++;
         $display("FAIL basic_latency: got v=%b p=%h pc=%h", if_parcel_valid, if_parcel, if_parcel_pc);
      end
`endif
      drain();
   endtask

   task automatic test_fill_stall();
      logic [31:0] a;
      for (int k = 0; k < 4; k++) begin
         a = 32'h200 + 32'(4 * k);
         cycle(0, a, 1, 0, 0, 0, 32'h0);
         cycle(0, a, 1, 0, 0, 0, 32'h0);
         cycle(0, a, 1, 0, 1, 0, 32'h1000 + a);
      end
      n_checks++;
      if (if_stall_nxt_pc !== 1'b1) begin
         n_fail++;
         $display("FAIL full_credit: got stall_nxt_pc=%b want 1", if_stall_nxt_pc);
      end
      cycle(0, 32'h210, 1, 0, 0, 0, 32'h0);
      n_checks++;
      if (imem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL full_no_req: got imem_req=%b want 0", imem_req);
      end
      for (int k = 0; k < 4; k++) begin
         drive(0, 32'h210, 0, 0, 0, 0, 32'h0);
         n_checks++;
         if ({if_parcel_valid, if_parcel_pc, if_parcel} !==
             {2'b11, 32'h200 + 32'(4 * k), 32'h1200 + 32'(4 * k)}) begin
            n_fail++;
            $display("FAIL pop_order[%0d]: got v=%b pc=%h p=%h", k, if_parcel_valid, if_parcel_pc, if_parcel);
         end
         tick();
      end
      drain();
   endtask

   task automatic test_flush_discard();
      cycle(0, 32'h300, 0, 0, 0, 0, 32'h0);
      cycle(0, 32'h300, 0, 0, 0, 0, 32'h0);
      cycle(0, 32'h300, 0, 1, 0, 0, 32'h0);
      cycle(0, 32'h100, 0, 0, 1, 0, 32'hDEADBEEF);
      n_checks++;
      if ({if_parcel_valid, imem_req} !== {2'b00, 1'b0}) begin
         n_fail++;
         $display("FAIL discard: got v=%b req=%b want 00/0", if_parcel_valid, imem_req);
      end
      cycle(0, 32'h100, 1, 0, 0, 0, 32'h0);
      cycle(0, 32'h104, 1, 0, 0, 0, 32'h0);
      cycle(0, 32'h104, 1, 0, 1, 0, 32'hCAFE0100);
      n_checks++;
      if ({if_parcel_valid, if_parcel_pc, if_parcel} !== {2'b11, 32'h100, 32'hCAFE0100}) begin
         n_fail++;
         $display("FAIL after_flush: got v=%b pc=%h p=%h", if_parcel_valid, if_parcel_pc, if_parcel);
      end
      drain();
   endtask

   task automatic test_misaligned();
      cycle(0, 32'h202, 1, 0, 0, 0, 32'h0);
      n_checks++;
      if ({imem_req, if_parcel_valid, if_parcel_pc, if_parcel, if_parcel_misaligned, if_parcel_page_fault}
          !== {1'b0, 2'b11, 32'h202, 32'h0, 1'b1, 1'b0}) begin
         n_fail++;
         $display("FAIL misaligned: got req=%b v=%b pc=%h p=%h m=%b f=%b", imem_req, if_parcel_valid,
                  if_parcel_pc, if_parcel, if_parcel_misaligned, if_parcel_page_fault);
      end
      drain();
   endtask

   task automatic test_page_fault();
      for (int both = 0; both < 2; both++) begin
         cycle(0, 32'h400, 1, 0, 0, 0, 32'h0);
         cycle(0, 32'h400, 1, 0, 0, 0, 32'h0);
         cycle(0, 32'h400, 1, 0, both[0], 1, 32'hFFFFFFFF);
         n_checks++;
         if ({if_parcel_valid, if_parcel_pc, if_parcel, if_parcel_misaligned, if_parcel_page_fault}
             !== {2'b11, 32'h400, 32'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL page_fault[%0d]: got v=%b pc=%h p=%h m=%b f=%b", both, if_parcel_valid,
                     if_parcel_pc, if_parcel, if_parcel_misaligned, if_parcel_page_fault);
         end
         drain();
      end
   endtask

   task automatic test_reset_mid_request();
      cycle(0, 32'h500, 0, 0, 0, 0, 32'h0);
      cycle(1, 32'h500, 0, 0, 0, 0, 32'h0);
      cycle(1, 32'h500, 0, 0, 1, 0, 32'h12345678);
      cycle(0, 32'h600, 0, 1, 1, 0, 32'h12345678);
      n_checks++;
      if ({imem_req, imem_adr, if_parcel_valid} !== {1'b0, 32'h200, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_mid_req: got req=%b adr=%h v=%b want 0/200/00", imem_req, imem_adr, if_parcel_valid);
      end
   endtask

   task automatic test_random();
      int          lat;
      int          kind;
      bit          prev_out;
      logic        r, st, fl, ak, er;
      logic [31:0] pc, dq;
      lat = 0;
      for (int i = 0; i < 800; i++) begin
         r  = ($urandom_range(0, 199) == 0);
         st = ($urandom_range(0, 9) < 4);
         fl = ($urandom_range(0, 19) == 0);
         pc = 32'($urandom_range(0, 'h3FF)) << 2;
         if ($urandom_range(0, 7) == 0) pc[1:0] = 2'($urandom_range(1, 3));
         dq = $urandom;
         ak = 0; er = 0;
         if (m_out) begin
            if (lat == 0) begin
               kind = $urandom_range(0, 9);
               ak = (kind < 8) || (kind == 9);
               er = (kind >= 8);
            end else begin
               lat--;
            end
         end else begin
            ak = ($urandom_range(0, 15) == 0);
         end
         prev_out = m_out;
         cycle(r, pc, st, fl, ak, er, dq);
         if (m_out && !prev_out) lat = $urandom_range(0, 3);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic_fetch();
      test_fill_stall();
      test_flush_discard();
      test_misaligned();
      test_page_fault();
      test_reset_mid_request();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
